// File: rtl/address_sum_diff_pkg.sv
// address_sum_diff_pkg
// Shared definitions for the address sum/diff pipeline:
//   - OP_ADD / OP_SUB : the two legal opcodes (octal 020 / 021)
//   - DEF_WIDTH / DEF_STAGES / DEF_TAG_W : default parameter values
//   - chunk_width() : bits handled per pipeline stage, ceil(width / stages)
package address_sum_diff_pkg;

    localparam logic [6:0] OP_ADD = 7'o020;
    localparam logic [6:0] OP_SUB = 7'o021;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 5;
    localparam int DEF_TAG_W  = 3;

    // Bits per stage; a degenerate stage count falls back to a single chunk
    // so that the elaboration check in the top reports the real problem.
    function automatic int chunk_width(input int width, input int stages);
        int result;
        if (stages < 1) begin
            result = width;
        end else begin
            result = (width + stages - 1) / stages;
        end
        return result;
    endfunction

endpackage

// File: rtl/address_chunk_adder.sv
// address_chunk_adder
// Adds one CW-bit slice of the operands with a carry-in and produces the
// slice sum and the carry-out for the next pipeline stage.
// Ports:
//   a, b  in  CW  operand slices (b already inverted for subtraction)
//   cin   in  1   carry from the previous slice
//   sum   out CW  slice result
//   cout  out 1   carry into the next slice
module address_chunk_adder #(
    parameter int CW = 1
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout
);

    logic [CW:0] total_s;

    // One extra bit captures the carry out of the slice.
    always_comb begin
        total_s = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
    end

    assign sum  = total_s[CW-1:0];
    assign cout = total_s[CW];

endmodule

// File: rtl/address_sum_diff_pipe.sv
// address_sum_diff_pipe
// Computes Ai = Aj + Ak (opcode 020) or Ai = Aj - Ak (opcode 021) modulo
// 2^WIDTH through a STAGES-deep carry-segmented pipeline. Each stage adds one
// CHUNK-wide slice; operands and the partial result travel together with the
// op. Latency from issue edge to retirement is STAGES cycles, throughput one
// op per cycle. Illegal opcodes travel the pipe and retire on o_err only.
//
// Ports:
//   clk, rst   clock; asynchronous active-high reset
//   i_valid    issue strobe (always accepted)
//   i_Instr    7-bit opcode
//   i_Aj/i_Ak  operands, WIDTH bits
//   i_tag      destination A-register index, TAG_W bits
//   o_valid    legal result retiring this cycle
//   o_Ai       result (holds between legal retirements)
//   o_tag      tag of the retiring result (holds likewise)
//   o_err      illegal opcode retiring this cycle
//   o_pending  bit t set while a legal op with tag t is in flight
//
// Build option: define ADDR_SUM_DIFF_PENDING_EN to generate o_pending; when
// undefined, o_pending is all zeros and no tag-compare logic is built.
module address_sum_diff_pipe
    import address_sum_diff_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES,
    parameter int TAG_W  = DEF_TAG_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [6:0]            i_Instr,
    input  logic [WIDTH-1:0]      i_Aj,
    input  logic [WIDTH-1:0]      i_Ak,
    input  logic [TAG_W-1:0]      i_tag,
    output logic                  o_valid,
    output logic [WIDTH-1:0]      o_Ai,
    output logic [TAG_W-1:0]      o_tag,
    output logic                  o_err,
    output logic [(1<<TAG_W)-1:0] o_pending
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);
    localparam int NTAG  = 1 << TAG_W;
    localparam int LAST  = STAGES - 1;

    if (STAGES < 1) begin : g_chk_stages
        $error("address_sum_diff_pipe: STAGES must be at least 1");
    end
    if (WIDTH < STAGES) begin : g_chk_width
        $error("address_sum_diff_pipe: WIDTH must be at least STAGES");
    end

    // Issue decode
    logic             is_add_s;
    logic             is_sub_s;
    logic [WIDTH-1:0] b_issue_s;

    // Stage inputs (what each stage sees this cycle)
    logic [STAGES-1:0] in_valid_s;
    logic [STAGES-1:0] in_err_s;
    logic [STAGES-1:0] in_c_s;
    logic [TAG_W-1:0]  in_tag_s [STAGES];
    logic [WIDTH-1:0]  in_a_s   [STAGES];
    logic [WIDTH-1:0]  in_b_s   [STAGES];
    logic [WIDTH-1:0]  in_res_s [STAGES];

    // Stage outputs before the stage register
    logic [STAGES-1:0] nxt_c_s;
    logic [WIDTH-1:0]  nxt_res_s [STAGES];

    // Stage registers
    logic [STAGES-1:0] valid_r;
    logic [STAGES-1:0] err_r;
    logic [STAGES-1:0] c_r;
    logic [TAG_W-1:0]  tag_r [STAGES];
    logic [WIDTH-1:0]  a_r   [STAGES];
    logic [WIDTH-1:0]  b_r   [STAGES];
    logic [WIDTH-1:0]  res_r [STAGES];

    logic last_legal_s;
    logic last_illegal_s;

    // Opcode decode; subtraction enters the adder chain as Aj + ~Ak + 1.
    always_comb begin
        is_add_s = (i_Instr == OP_ADD);
        is_sub_s = (i_Instr == OP_SUB);
        if (is_sub_s) begin
            b_issue_s = ~i_Ak;
        end else begin
            b_issue_s = i_Ak;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CHUNK;
        localparam int HI = ((k + 1) * CHUNK > WIDTH) ? WIDTH : (k + 1) * CHUNK;

        if (k == 0) begin : g_src
            assign in_valid_s[k] = i_valid;
            assign in_err_s[k]   = !(is_add_s || is_sub_s);
            assign in_c_s[k]     = is_sub_s;
            assign in_tag_s[k]   = i_tag;
            assign in_a_s[k]     = i_Aj;
            assign in_b_s[k]     = b_issue_s;
            assign in_res_s[k]   = '0;
        end else begin : g_src
            assign in_valid_s[k] = valid_r[k-1];
            assign in_err_s[k]   = err_r[k-1];
            assign in_c_s[k]     = c_r[k-1];
            assign in_tag_s[k]   = tag_r[k-1];
            assign in_a_s[k]     = a_r[k-1];
            assign in_b_s[k]     = b_r[k-1];
            assign in_res_s[k]   = res_r[k-1];
        end

        if (HI > LO) begin : g_add
            logic [HI-LO-1:0] sum_s;
            logic [WIDTH-1:0] sum_ext_s;

            address_chunk_adder #(
                .CW (HI - LO)
            ) u_adder (
                .a    (in_a_s[k][HI-1:LO]),
                .b    (in_b_s[k][HI-1:LO]),
                .cin  (in_c_s[k]),
                .sum  (sum_s),
                .cout (nxt_c_s[k])
            );

            // Result bits at and above LO are still zero here, so OR-ing the
            // shifted slice splices it into the travelling result.
            assign sum_ext_s    = WIDTH'(sum_s);
            assign nxt_res_s[k] = in_res_s[k] | (sum_ext_s << LO);
        end else begin : g_pass
            // Empty trailing stage: pure delay for data and carry.
            assign nxt_res_s[k] = in_res_s[k];
            assign nxt_c_s[k]   = in_c_s[k];
        end
    end

    // Pipeline stage registers; reset discards every in-flight op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
            err_r   <= '0;
            c_r     <= '0;
            for (int k = 0; k < STAGES; k++) begin
                tag_r[k] <= '0;
                a_r[k]   <= '0;
                b_r[k]   <= '0;
                res_r[k] <= '0;
            end
        end else begin
            valid_r <= in_valid_s;
            err_r   <= in_err_s;
            c_r     <= nxt_c_s;
            for (int k = 0; k < STAGES; k++) begin
                tag_r[k] <= in_tag_s[k];
                a_r[k]   <= in_a_s[k];
                b_r[k]   <= in_b_s[k];
                res_r[k] <= nxt_res_s[k];
            end
        end
    end

    assign last_legal_s   = valid_r[LAST] && !err_r[LAST];
    assign last_illegal_s = valid_r[LAST] && err_r[LAST];

    // Retirement register; result and tag only move on a legal retirement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_err   <= 1'b0;
            o_Ai    <= '0;
            o_tag   <= '0;
        end else begin
            o_valid <= last_legal_s;
            o_err   <= last_illegal_s;
            if (last_legal_s) begin
                o_Ai  <= res_r[LAST];
                o_tag <= tag_r[LAST];
            end else begin
                o_Ai  <= o_Ai;
                o_tag <= o_tag;
            end
        end
    end

`ifdef ADDR_SUM_DIFF_PENDING_EN
    logic [NTAG-1:0] pend_s;

    // OR of one-hot tags over every live legal op, including the one sitting
    // in the retirement register, so a bit drops only after the last retires.
    always_comb begin
        pend_s = '0;
        for (int k = 0; k < STAGES; k++) begin
            pend_s = pend_s
                   | ({{(NTAG-1){1'b0}}, (valid_r[k] && !err_r[k])} << tag_r[k]);
        end
        pend_s = pend_s | ({{(NTAG-1){1'b0}}, o_valid} << o_tag);
    end

    assign o_pending = pend_s;
`else
    assign o_pending = '0;
`endif

    // The final carry and the fully consumed operands are intentionally dropped.
    logic unused_s;
    assign unused_s = ^{c_r[LAST], a_r[LAST], b_r[LAST]};

endmodule

// File: tb/tb_address_sum_diff_pipe.sv
// tb_address_sum_diff_pipe
// Self-checking bench: a vector table and directed sequences on the default
// configuration, plus a randomized phase where three configurations
// (32/5, 16/3, 8/8) receive the same stimulus and are compared every cycle
// against an issue-history reference model.
module tb_address_sum_diff_pipe;
    import address_sum_diff_pkg::*;

`ifdef ADDR_SUM_DIFF_PENDING_EN
    localparam bit PEND_EN = 1'b1;
`else
    localparam bit PEND_EN = 1'b0;
`endif

    localparam int S0   = 5;
    localparam int MAXE = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [6:0]  i_instr;
    logic [31:0] aj, ak;
    logic [2:0]  itag;

    logic        ov0, oe0, ov1, oe1, ov2, oe2;
    logic [31:0] oai0;
    logic [15:0] oai1;
    logic [7:0]  oai2;
    logic [2:0]  otag0, otag1, otag2;
    logic [7:0]  opend0, opend1, opend2;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    logic        hv   [MAXE];
    logic        hrst [MAXE];
    logic [6:0]  hop  [MAXE];
    logic [31:0] ha   [MAXE];
    logic [31:0] hb   [MAXE];
    logic [2:0]  ht   [MAXE];
    logic [31:0] held_ai  [3];
    logic [2:0]  held_tag [3];

    always #5 clk = ~clk;

    address_sum_diff_pipe #(.WIDTH(32), .STAGES(5), .TAG_W(3)) u_dut0 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_Instr(i_instr),
        .i_Aj(aj), .i_Ak(ak), .i_tag(itag),
        .o_valid(ov0), .o_Ai(oai0), .o_tag(otag0), .o_err(oe0), .o_pending(opend0));

    address_sum_diff_pipe #(.WIDTH(16), .STAGES(3), .TAG_W(3)) u_dut1 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_Instr(i_instr),
        .i_Aj(aj[15:0]), .i_Ak(ak[15:0]), .i_tag(itag),
        .o_valid(ov1), .o_Ai(oai1), .o_tag(otag1), .o_err(oe1), .o_pending(opend1));

    address_sum_diff_pipe #(.WIDTH(8), .STAGES(8), .TAG_W(3)) u_dut2 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_Instr(i_instr),
        .i_Aj(aj[7:0]), .i_Ak(ak[7:0]), .i_tag(itag),
        .o_valid(ov2), .o_Ai(oai2), .o_tag(otag2), .o_err(oe2), .o_pending(opend2));

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference arithmetic: plain modular add/subtract at the given width.
    function automatic logic [31:0] ref_res(input logic [6:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input int w);
        longint unsigned m, sa, sb, r;
        m  = (64'd1 << w) - 64'd1;
        sa = 64'(a);
        sb = 64'(b);
        if (op == OP_ADD) r = (sa + sb) & m;
        else              r = (sa - sb) & m;
        return r[31:0];
    endfunction

    // An op issued at edge n is still alive at edge m if it was captured and
    // no reset was seen at any edge from n to m.
    function automatic bit alive(input int n, input int m);
        if (n < 0) return 1'b0;
        if (!hv[n]) return 1'b0;
        for (int j = n; j <= m; j++) begin
            if (hrst[j]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_check(input int d, input int w, input int s, input int m,
                               input logic ov, input logic oe, input logic [31:0] oai,
                               input logic [2:0] otag, input logic [7:0] opend);
        logic       ev, ee;
        logic [7:0] ep;
        bit         legal;
        int         n;
        ev = 1'b0; ee = 1'b0; ep = 8'h00;
        if (rst) begin
            held_ai[d]  = 32'h0;
            held_tag[d] = 3'd0;
        end else begin
            for (int k = 0; k <= s; k++) begin
                n = m - k;
                if (alive(n, m)) begin
                    legal = (hop[n] == OP_ADD) || (hop[n] == OP_SUB);
                    if (k == s) begin
                        if (legal) begin
                            ev = 1'b1;
                            held_ai[d]  = ref_res(hop[n], ha[n], hb[n], w);
                            held_tag[d] = ht[n];
                        end else begin
                            ee = 1'b1;
                        end
                    end
                    if (legal && PEND_EN) ep[ht[n]] = 1'b1;
                end
            end
        end
        chk($sformatf("d%0d_o_valid@%0d", d, m), 64'(ov), 64'(ev));
        chk($sformatf("d%0d_o_err@%0d", d, m), 64'(oe), 64'(ee));
        chk($sformatf("d%0d_o_Ai@%0d", d, m), 64'(oai), 64'(held_ai[d]));
        chk($sformatf("d%0d_o_tag@%0d", d, m), 64'(otag), 64'(held_tag[d]));
        chk($sformatf("d%0d_o_pending@%0d", d, m), 64'(opend), 64'(ep));
    endtask

    // Record what each rising edge samples.
    always @(posedge clk) begin
        if (edge_n < MAXE) begin
            hv[edge_n]   <= i_valid;
            hrst[edge_n] <= rst;
            hop[edge_n]  <= i_instr;
            ha[edge_n]   <= aj;
            hb[edge_n]   <= ak;
            ht[edge_n]   <= itag;
        end
        edge_n <= edge_n + 1;
    end

    // Compare every configuration against the model mid-cycle.
    always @(negedge clk) begin
        if (edge_n >= 1 && edge_n <= MAXE) begin
            model_check(0, 32, 5, edge_n - 1, ov0, oe0, oai0, otag0, opend0);
            model_check(1, 16, 3, edge_n - 1, ov1, oe1, {16'h0, oai1}, otag1, opend1);
            model_check(2, 8, 8, edge_n - 1, ov2, oe2, {24'h0, oai2}, otag2, opend2);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] t);
        i_valid = v; i_instr = op; aj = a; ak = b; itag = t;
    endtask

    typedef struct {
        logic [6:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  tag;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{OP_ADD, 32'd5,          32'd7,          3'd3, 32'd12};
        tbl[1] = '{OP_SUB, 32'd3,          32'd5,          3'd0, 32'hFFFF_FFFE};
        tbl[2] = '{OP_ADD, 32'hFFFF_FFFF,  32'd1,          3'd5, 32'h0000_0000};
        tbl[3] = '{OP_ADD, 32'h0000_FFFF,  32'd1,          3'd7, 32'h0001_0000};
        tbl[4] = '{OP_SUB, 32'd0,          32'd1,          3'd1, 32'hFFFF_FFFF};
        tbl[5] = '{OP_ADD, 32'h8000_0000,  32'h8000_0000,  3'd2, 32'h0000_0000};
        tbl[6] = '{OP_SUB, 32'h1234_5678,  32'h1234_5678,  3'd4, 32'h0000_0000};
        tbl[7] = '{OP_ADD, 32'h7FFF_FFFF,  32'd1,          3'd6, 32'h8000_0000};

        rst = 1'b1;
        drive(1'b0, OP_ADD, 32'h0, 32'h0, 3'd0);
        repeat (3) tick();
        chk("reset_o_valid", 64'(ov0), 64'd0);
        chk("reset_o_err", 64'(oe0), 64'd0);
        chk("reset_o_Ai", 64'(oai0), 64'd0);
        chk("reset_o_tag", 64'(otag0), 64'd0);
        chk("reset_o_pending", 64'(opend0), 64'd0);
        rst = 1'b0;
        tick();

        // Vector table: one op at a time, exact latency.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].tag);
            tick();
            drive(1'b0, OP_ADD, 32'h0, 32'h0, 3'd0);
            chk($sformatf("vec%0d_pending_after_issue", i), 64'(opend0[tbl[i].tag]), 64'(PEND_EN));
            repeat (S0 - 1) tick();
            chk($sformatf("vec%0d_not_early", i), 64'(ov0), 64'd0);
            tick();
            chk($sformatf("vec%0d_o_valid", i), 64'(ov0), 64'd1);
            chk($sformatf("vec%0d_o_Ai", i), 64'(oai0), 64'(tbl[i].exp));
            chk($sformatf("vec%0d_o_tag", i), 64'(otag0), 64'(tbl[i].tag));
            chk($sformatf("vec%0d_o_err", i), 64'(oe0), 64'd0);
            tick();
            chk($sformatf("vec%0d_valid_drops", i), 64'(ov0), 64'd0);
        end

        // Back-to-back add / illegal / sub.
        drive(1'b1, OP_ADD, 32'd10, 32'd20, 3'd1); tick();
        drive(1'b1, 7'o077, 32'd10, 32'd20, 3'd2); tick();
        drive(1'b1, OP_SUB, 32'd10, 32'd20, 3'd4); tick();
        drive(1'b0, OP_ADD, 32'h0, 32'h0, 3'd0);
        chk("b2b_pend2_inflight", 64'(opend0[2]), 64'd0);
        repeat (3) tick();
        chk("b2b_add_valid", 64'(ov0), 64'd1);
        chk("b2b_add_Ai", 64'(oai0), 64'd30);
        chk("b2b_add_tag", 64'(otag0), 64'd1);
        chk("b2b_pend2_a", 64'(opend0[2]), 64'd0);
        tick();
        chk("b2b_ill_err", 64'(oe0), 64'd1);
        chk("b2b_ill_valid", 64'(ov0), 64'd0);
        chk("b2b_ill_Ai_held", 64'(oai0), 64'd30);
        chk("b2b_ill_tag_held", 64'(otag0), 64'd1);
        chk("b2b_pend2_b", 64'(opend0[2]), 64'd0);
        tick();
        chk("b2b_sub_valid", 64'(ov0), 64'd1);
        chk("b2b_sub_err", 64'(oe0), 64'd0);
        chk("b2b_sub_Ai", 64'(oai0), 64'hFFFF_FFF6);
        chk("b2b_sub_tag", 64'(otag0), 64'd4);
        tick();

        // Two tag-6 ops two cycles apart keep o_pending[6] continuously set.
        drive(1'b1, OP_ADD, 32'd1, 32'd1, 3'd6); tick();
        drive(1'b0, OP_ADD, 32'h0, 32'h0, 3'd0);
        chk("pend6_c0", 64'(opend0[6]), 64'(PEND_EN));
        tick();
        chk("pend6_c1", 64'(opend0[6]), 64'(PEND_EN));
        drive(1'b1, OP_ADD, 32'd2, 32'd2, 3'd6); tick();
        drive(1'b0, OP_ADD, 32'h0, 32'h0, 3'd0);
        for (int c = 2; c <= 7; c++) begin
            chk($sformatf("pend6_c%0d", c), 64'(opend0[6]), 64'(PEND_EN));
            tick();
        end
        chk("pend6_cleared", 64'(opend0[6]), 64'd0);
        chk("pend6_last_Ai", 64'(oai0), 64'd4);

        // Reset with three ops in flight.
        drive(1'b1, OP_ADD, 32'd1, 32'd2, 3'd1); tick();
        drive(1'b1, OP_ADD, 32'd3, 32'd4, 3'd2); tick();
        drive(1'b1, OP_SUB, 32'd9, 32'd4, 3'd3); tick();
        drive(1'b0, OP_ADD, 32'h0, 32'h0, 3'd0);
        rst = 1'b1;
        #1;
        chk("midrst_o_valid", 64'(ov0), 64'd0);
        chk("midrst_o_Ai", 64'(oai0), 64'd0);
        chk("midrst_o_tag", 64'(otag0), 64'd0);
        chk("midrst_o_pending", 64'(opend0), 64'd0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("midrst_no_retire%0d", c), 64'(ov0), 64'd0);
        end
        drive(1'b1, OP_ADD, 32'd100, 32'd23, 3'd5); tick();
        drive(1'b0, OP_ADD, 32'h0, 32'h0, 3'd0);
        repeat (S0 - 1) tick();
        chk("postrst_not_early", 64'(ov0), 64'd0);
        tick();
        chk("postrst_valid", 64'(ov0), 64'd1);
        chk("postrst_Ai", 64'(oai0), 64'd123);
        chk("postrst_tag", 64'(otag0), 64'd5);

        // Randomized phase; all three configurations checked by the model.
        for (int c = 0; c < 800; c++) begin
            int r;
            logic [6:0] op;
            r = int'($urandom_range(0, 9));
            if (r < 5)      op = OP_ADD;
            else if (r < 9) op = OP_SUB;
            else            op = 7'($urandom_range(0, 15));
            drive(($urandom_range(0, 3) != 0),
                  op,
                  ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom,
                  ($urandom_range(0, 7) == 0) ? 32'h0000_0001 : $urandom,
                  3'($urandom_range(0, 7)));
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        drive(1'b0, OP_ADD, 32'h0, 32'h0, 3'd0);
        repeat (12) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
